// File: rtl/line_assembler.sv
// rtl/line_assembler.sv - collects received bytes into a terminated line and presents it for capture (optional LINE_ASSEMBLER_BACKSPACE_EN)
module line_assembler #(
    parameter int          LENGTH      = 16,
    parameter logic [7:0]  EOL         = 8'h0A,
    parameter logic [7:0]  CR          = 8'h0D,
    localparam int         LENGTH_BITS = $clog2(LENGTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [7:0]              i_byte,
    input  logic                    i_byte_valid,
    input  logic                    i_ack,
    output logic [LENGTH*8-1:0]     o_line,
    output logic [LENGTH_BITS-1:0]  o_len,
    output logic                    o_ready,
    output logic                    o_overflow,
    output logic [7:0]              o_echo,
    output logic                    o_echo_valid
);

    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // The last slot is always kept free so a terminator can still be stored.
    localparam logic [LENGTH_BITS-1:0] LAST_CHAR = LENGTH_BITS'(LENGTH - 2);
    localparam logic [LENGTH_BITS-1:0] ONE       = LENGTH_BITS'(1);

    state_t                  state;
    logic                    is_term;
    logic [LENGTH_BITS+2:0]  wr_ptr;

    assign is_term = (i_byte == EOL) || (i_byte == CR);
    assign wr_ptr  = {o_len, 3'b000};

`ifdef LINE_ASSEMBLER_BACKSPACE_EN
    logic                    is_bs;
    logic [LENGTH_BITS-1:0]  prev_len;
    logic [LENGTH_BITS+2:0]  bs_ptr;

    assign is_bs    = (i_byte == 8'h08) || (i_byte == 8'h7F);
    assign prev_len = o_len - ONE;
    assign bs_ptr   = {prev_len, 3'b000};
`endif

    // Line fill / present state machine with registered line, length, flags and echo
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= FILL;
            o_line       <= '0;
            o_len        <= '0;
            o_ready      <= 1'b0;
            o_overflow   <= 1'b0;
            o_echo       <= 8'h00;
            o_echo_valid <= 1'b0;
        end else if (!i_en) begin
            o_echo_valid <= 1'b0;
        end else begin
            o_echo_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (i_byte_valid) begin
                        if (is_term) begin
                            // Terminators are normalised to EOL in both buffer and echo.
                            o_line[wr_ptr +: 8] <= EOL;
                            o_len               <= o_len + ONE;
                            o_echo              <= EOL;
                            o_echo_valid        <= 1'b1;
                            o_ready             <= 1'b1;
                            state               <= PRESENT;
`ifdef LINE_ASSEMBLER_BACKSPACE_EN
                        end else if (is_bs) begin
                            // Erase the previous character; nothing to erase at an empty line.
                            if (o_len != '0) begin
                                o_line[bs_ptr +: 8] <= 8'h00;
                                o_len               <= prev_len;
                                o_echo              <= 8'h08;
                                o_echo_valid        <= 1'b1;
                            end
`endif
                        end else if (o_len < LAST_CHAR) begin
                            o_line[wr_ptr +: 8] <= i_byte;
                            o_len               <= o_len + ONE;
                            o_echo              <= i_byte;
                            o_echo_valid        <= 1'b1;
                        end else begin
                            o_overflow <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    // Bytes arriving while a line is presented are discarded silently.
                    if (i_ack) begin
                        o_line     <= '0;
                        o_len      <= '0;
                        o_ready    <= 1'b0;
                        o_overflow <= 1'b0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_line_assembler.sv
// tb/tb_line_assembler.sv - scoreboard testbench for line_assembler
module tb_line_assembler;

    localparam int LENGTH = 16;
    localparam int LB     = $clog2(LENGTH);

    logic                   i_clk = 1'b0;
    logic                   i_rst_n = 1'b0;
    logic                   i_en = 1'b1;
    logic [7:0]             i_byte = 8'h00;
    logic                   i_byte_valid = 1'b0;
    logic                   i_ack = 1'b0;
    logic [LENGTH*8-1:0]    o_line;
    logic [LB-1:0]          o_len;
    logic                   o_ready;
    logic                   o_overflow;
    logic [7:0]             o_echo;
    logic                   o_echo_valid;

    int checks = 0;
    int failures = 0;

    logic [LENGTH*8-1:0] m_line;
    int                  m_len;
    bit                  m_ready;
    bit                  m_ovf;
    logic [7:0]          echo_q[$];

    line_assembler #(.LENGTH(LENGTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_byte(i_byte),
        .i_byte_valid(i_byte_valid), .i_ack(i_ack), .o_line(o_line), .o_len(o_len),
        .o_ready(o_ready), .o_overflow(o_overflow), .o_echo(o_echo), .o_echo_valid(o_echo_valid)
    );

    always #5 i_clk = ~i_clk;

    // Echo scoreboard: every echo strobe must match the oldest expected echo.
    always @(negedge i_clk) begin
        if (i_rst_n && o_echo_valid) begin
            checks++;
            if (echo_q.size() == 0) begin
                failures++;
                $display("FAIL echo_unexpected got=%02h required=none", o_echo);
            end else begin
                logic [7:0] e;
                e = echo_q.pop_front();
                if (o_echo !== e) begin
                    failures++;
                    $display("FAIL echo_value got=%02h required=%02h", o_echo, e);
                end
            end
        end
    end

    task automatic model_clear();
        m_line  = '0;
        m_len   = 0;
        m_ready = 0;
        m_ovf   = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_ready) begin
        end else if (b == 8'h0A || b == 8'h0D) begin
            m_line[m_len*8 +: 8] = 8'h0A;
            m_len++;
            m_ready = 1;
            echo_q.push_back(8'h0A);
`ifdef LINE_ASSEMBLER_BACKSPACE_EN
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (m_len > 0) begin
                m_len--;
                m_line[m_len*8 +: 8] = 8'h00;
                echo_q.push_back(8'h08);
            end
`endif
        end else if (m_len < LENGTH - 2) begin
            m_line[m_len*8 +: 8] = b;
            m_len++;
            echo_q.push_back(b);
        end else begin
            m_ovf = 1;
        end
    endtask

    // Caller is always positioned 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b);
        model_byte(b);
        i_byte = b;
        i_byte_valid = 1'b1;
        @(posedge i_clk); #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic do_ack();
        if (m_ready) model_clear();
        i_ack = 1'b1;
        @(posedge i_clk); #1;
        i_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        model_clear();
        idle(2);
        checks += 6;
        if (o_line !== '0) begin failures++; $display("FAIL reset_line got=%0h required=0", o_line); end
        if (o_len !== '0) begin failures++; $display("FAIL reset_len got=%0d required=0", o_len); end
        if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b required=0", o_ready); end
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b required=0", o_overflow); end
        if (o_echo !== 8'h00) begin failures++; $display("FAIL reset_echo got=%02h required=00", o_echo); end
        if (o_echo_valid !== 1'b0) begin failures++; $display("FAIL reset_echo_valid got=%b required=0", o_echo_valid); end
        i_rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        send("1"); send("2"); send("+"); send(8'h0D);
        idle(1);
        checks += 5;
        if (o_line[31:0] !== 32'h0A2B3231) begin failures++; $display("FAIL basic_line got=%08h required=0a2b3231", o_line[31:0]); end
        if (o_line !== m_line) begin failures++; $display("FAIL basic_line_full got=%0h required=%0h", o_line, m_line); end
        if (o_len !== LB'(4)) begin failures++; $display("FAIL basic_len got=%0d required=4", o_len); end
        if (o_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b required=1", o_ready); end
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b required=0", o_overflow); end
        do_ack();
        checks += 2;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL basic_ack_ready got=%b required=0", o_ready); end
        if (o_len !== '0) begin failures++; $display("FAIL basic_ack_len got=%0d required=0", o_len); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) send("A");
        checks += 1;
        if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag_before_eol got=%b required=1", o_overflow); end
        send(8'h0A);
        idle(1);
        checks += 4;
        if (o_len !== LB'(15)) begin failures++; $display("FAIL ovf_len got=%0d required=15", o_len); end
        if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b required=1", o_overflow); end
        if (o_line[119:112] !== 8'h0A) begin failures++; $display("FAIL ovf_eol_slot got=%02h required=0a", o_line[119:112]); end
        if (o_line !== m_line) begin failures++; $display("FAIL ovf_line got=%0h required=%0h", o_line, m_line); end
        do_ack();
        checks += 1;
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b required=0", o_overflow); end
    endtask

    task automatic test_ack_with_byte();
        send("h"); send("i"); send(8'h0A);
        idle(1);
        // Byte and ack together: the model drops the byte and clears the line.
        i_byte = "X";
        i_byte_valid = 1'b1;
        do_ack();
        i_byte_valid = 1'b0;
        checks += 3;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL ackbyte_ready got=%b required=0", o_ready); end
        if (o_len !== '0) begin failures++; $display("FAIL ackbyte_len got=%0d required=0", o_len); end
        if (o_line !== '0) begin failures++; $display("FAIL ackbyte_line got=%0h required=0", o_line); end
    endtask

    task automatic test_ack_in_fill();
        send("q");
        i_ack = 1'b1;
        @(posedge i_clk); #1;
        i_ack = 1'b0;
        checks += 2;
        if (o_len !== LB'(1)) begin failures++; $display("FAIL fillack_len got=%0d required=1", o_len); end
        if (o_line[7:0] !== 8'h71) begin failures++; $display("FAIL fillack_char got=%02h required=71", o_line[7:0]); end
        send(8'h0A);
        do_ack();
    endtask

    task automatic test_reset_mid();
        send("a"); send("b");
        idle(1);
        i_rst_n = 1'b0;
        #1;
        model_clear();
        checks += 1;
        if (o_len !== '0) begin failures++; $display("FAIL midrst_async_len got=%0d required=0", o_len); end
        idle(1);
        i_rst_n = 1'b1;
        idle(1);
        send("c"); send(8'h0A);
        idle(1);
        checks += 3;
        if (o_line[15:0] !== 16'h0A63) begin failures++; $display("FAIL midrst_line got=%04h required=0a63", o_line[15:0]); end
        if (o_len !== LB'(2)) begin failures++; $display("FAIL midrst_len got=%0d required=2", o_len); end
        if (o_line !== m_line) begin failures++; $display("FAIL midrst_line_full got=%0h required=%0h", o_line, m_line); end
        do_ack();
    endtask

    task automatic test_backspace();
        send(8'h08);
`ifdef LINE_ASSEMBLER_BACKSPACE_EN
        checks += 1;
        if (o_len !== '0) begin failures++; $display("FAIL bs_leading_len got=%0d required=0", o_len); end
`else
        checks += 1;
        if (o_len !== LB'(1)) begin failures++; $display("FAIL bs_plain_leading_len got=%0d required=1", o_len); end
        // Start the comparison sequence from an empty line.
        send(8'h0A);
        do_ack();
`endif
        send("a"); send("b"); send(8'h7F); send("c"); send(8'h0A);
        idle(1);
        checks += 2;
`ifdef LINE_ASSEMBLER_BACKSPACE_EN
        if (o_len !== LB'(3)) begin failures++; $display("FAIL bs_len got=%0d required=3", o_len); end
        if (o_line[23:0] !== 24'h0A6361) begin failures++; $display("FAIL bs_line got=%06h required=0a6361", o_line[23:0]); end
`else
        if (o_len !== LB'(5)) begin failures++; $display("FAIL bs_plain_len got=%0d required=5", o_len); end
        if (o_line[39:0] !== 40'h0A637F6261) begin failures++; $display("FAIL bs_plain_line got=%010h required=0a637f6261", o_line[39:0]); end
`endif
        do_ack();
    endtask

    task automatic test_enable();
        send("e");
        i_en = 1'b0;
        i_byte = "Z";
        i_byte_valid = 1'b1;
        @(posedge i_clk); #1;
        i_byte_valid = 1'b0;
        checks += 1;
        if (o_len !== LB'(1)) begin failures++; $display("FAIL en_fill_len got=%0d required=1", o_len); end
        i_en = 1'b1;
        send(8'h0A);
        idle(1);
        i_en = 1'b0;
        i_byte_valid = 1'b1;
        i_ack = 1'b1;
        @(posedge i_clk); #1;
        checks += 3;
        if (o_echo_valid !== 1'b0) begin failures++; $display("FAIL en_echo_valid got=%b required=0", o_echo_valid); end
        i_byte_valid = 1'b0;
        i_ack = 1'b0;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL en_ready_held got=%b required=1", o_ready); end
        if (o_len !== LB'(2)) begin failures++; $display("FAIL en_len_held got=%0d required=2", o_len); end
        i_en = 1'b1;
        do_ack();
    endtask

    task automatic test_back_to_back();
        for (int l = 0; l < 4; l++) begin
            int n;
            n = $urandom_range(0, 17);
            for (int i = 0; i < n; i++) send(8'($urandom_range(8'h61, 8'h7A)));
            send(8'h0A);
            idle(1);
            checks += 3;
            if (o_line !== m_line) begin failures++; $display("FAIL b2b_line got=%0h required=%0h", o_line, m_line); end
            if (o_len !== LB'(m_len)) begin failures++; $display("FAIL b2b_len got=%0d required=%0d", o_len, m_len); end
            if (o_overflow !== m_ovf) begin failures++; $display("FAIL b2b_ovf got=%b required=%b", o_overflow, m_ovf); end
            do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ack_with_byte();
        test_ack_in_fill();
        test_reset_mid();
        test_backspace();
        test_enable();
        test_back_to_back();
        idle(3);
        checks++;
        if (echo_q.size() != 0) begin
            failures++;
            $display("FAIL echo_missing got=%0d outstanding required=0", echo_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
